// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter: configuration and strobes in,
// count and flags out.
interface prog_counter_if #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
);
  logic             i_en;
  logic             i_clr;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_up;
  logic [WIDTH-1:0] i_max;
  logic             i_sat;
  logic [PW-1:0]    i_presc;
  logic             i_ovf_clr;
  logic [WIDTH-1:0] o_cnt;
  logic             o_tc;
  logic             o_wrap;
  logic             o_ovf;

  modport master (
    output i_en, i_clr, i_load, i_load_val, i_up, i_max, i_sat, i_presc, i_ovf_clr,
    input  o_cnt, o_tc, o_wrap, o_ovf
  );

  modport slave (
    input  i_en, i_clr, i_load, i_load_val, i_up, i_max, i_sat, i_presc, i_ovf_clr,
    output o_cnt, o_tc, o_wrap, o_ovf
  );
endinterface

// File: rtl/prog_counter.sv
// Programmable-modulus up/down counter with prescaler, wrap/saturate modes,
// one-cycle wrap pulse and sticky overflow flag.
module prog_counter #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  prog_counter_if.slave bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             tc, tick, step;

  // Up-mode uses >= so a count sitting above i_max is treated as terminal.
  assign tc   = bus.i_up ? (cnt_q >= bus.i_max) : (cnt_q == '0);
  assign tick = bus.i_en && (p_q == bus.i_presc);
  assign step = tick && !bus.i_clr && !bus.i_load;

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.i_clr) begin
      cnt_d = '0;
      p_d   = '0;
    end else if (bus.i_load) begin
      cnt_d = bus.i_load_val;
      p_d   = '0;
    end else begin
      if (bus.i_en) p_d = tick ? '0 : p_q + 1'b1;
      if (step) begin
        if (bus.i_up) begin
          if (!tc)            cnt_d = cnt_q + 1'b1;
          else if (bus.i_sat) cnt_d = bus.i_max;
          else begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          if (!tc)             cnt_d = cnt_q - 1'b1;
          else if (!bus.i_sat) begin
            cnt_d  = bus.i_max;
            wrap_d = 1'b1;
          end
        end
      end
    end
    // A terminal step beats a same-cycle clear request.
    if (step && tc)         ovf_d = 1'b1;
    else if (bus.i_ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      p_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.o_cnt  = cnt_q;
  assign bus.o_tc   = tc;
  assign bus.o_wrap = wrap_q;
  assign bus.o_ovf  = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed test-plan scenarios plus randomized traffic, all checked against
// an integer reference model of the counter rules.
module tb_prog_counter;
  localparam int W  = 8;
  localparam int PW = 4;
  localparam int M  = 1 << W;
  localparam int PM = 1 << PW;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  prog_counter_if #(.WIDTH(W), .PW(PW)) bus();
  prog_counter #(.WIDTH(W), .PW(PW)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int m_cnt, m_p;
  bit m_wrap, m_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit m_tc();
    if (bus.i_up) return m_cnt >= int'(bus.i_max);
    return m_cnt == 0;
  endfunction

  // Apply the counter rules for one rising edge using the current inputs.
  task automatic m_edge();
    bit tc, tick, step;
    if (!i_rst_n) begin
      m_cnt = 0; m_p = 0; m_wrap = 0; m_ovf = 0;
      return;
    end
    tc   = m_tc();
    tick = bus.i_en && (m_p == int'(bus.i_presc));
    step = tick && !bus.i_clr && !bus.i_load;
    m_wrap = 0;
    if (bus.i_clr || bus.i_load) m_p = 0;
    else if (bus.i_en) m_p = tick ? 0 : (m_p + 1) % PM;
    if (bus.i_clr) m_cnt = 0;
    else if (bus.i_load) m_cnt = int'(bus.i_load_val);
    else if (step) begin
      if (bus.i_up) begin
        if (!tc) m_cnt = (m_cnt + 1) % M;
        else if (bus.i_sat) m_cnt = int'(bus.i_max);
        else begin m_cnt = 0; m_wrap = 1; end
      end else begin
        if (!tc) m_cnt = m_cnt - 1;
        else if (!bus.i_sat) begin m_cnt = int'(bus.i_max); m_wrap = 1; end
      end
    end
    if (step && tc) m_ovf = 1;
    else if (bus.i_ovf_clr) m_ovf = 0;
  endtask

  // One clock: check o_tc against current inputs, clock, check registers.
  task automatic cyc();
    #1;
    if (i_rst_n) chk("tc", 32'(bus.o_tc), 32'(m_tc()));
    m_edge();
    @(posedge i_clk);
    @(negedge i_clk);
    chk("cnt", 32'(bus.o_cnt), 32'(m_cnt));
    chk("wrap", 32'(bus.o_wrap), 32'(m_wrap));
    chk("ovf", 32'(bus.o_ovf), 32'(m_ovf));
  endtask

  task automatic idle();
    bus.i_en = 0; bus.i_clr = 0; bus.i_load = 0; bus.i_ovf_clr = 0;
  endtask

  initial begin
    idle();
    bus.i_load_val = '0; bus.i_up = 1; bus.i_max = 8'd17; bus.i_sat = 0; bus.i_presc = '0;
    m_cnt = 0; m_p = 0; m_wrap = 0; m_ovf = 0;

    // reset
    i_rst_n = 0;
    cyc(); cyc();
    chk("rst_cnt", 32'(bus.o_cnt), 0);
    chk("rst_ovf", 32'(bus.o_ovf), 0);
    bus.i_up = 0; #1;
    chk("rst_tc_down", 32'(bus.o_tc), 1);
    bus.i_up = 1;

    // legacy mod-18
    i_rst_n = 1; bus.i_en = 1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk("legacy_cnt", 32'(bus.o_cnt), 32'(k % 18));
      chk("legacy_wrap", 32'(bus.o_wrap), 32'(k % 18 == 0));
    end
    chk("legacy_ovf", 32'(bus.o_ovf), 1);

    // down count with saturation
    idle(); bus.i_ovf_clr = 1; cyc(); bus.i_ovf_clr = 0;
    chk("ovf_clr", 32'(bus.o_ovf), 0);
    bus.i_up = 0; bus.i_sat = 1; bus.i_load = 1; bus.i_load_val = 8'd3; cyc();
    bus.i_load = 0; bus.i_en = 1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("dsat_cnt", 32'(bus.o_cnt), 32'((k < 3) ? 2 - k : 0));
      chk("dsat_wrap", 32'(bus.o_wrap), 0);
    end
    chk("dsat_ovf", 32'(bus.o_ovf), 1);
    bus.i_ovf_clr = 1; cyc(); bus.i_ovf_clr = 0;
    chk("ovf_set_wins", 32'(bus.o_ovf), 1);

    // prescaler
    idle(); bus.i_up = 1; bus.i_sat = 0; bus.i_max = 8'd17; bus.i_clr = 1; cyc();
    bus.i_clr = 0; bus.i_presc = 4'd2;
    begin
      bit en_pat [7] = '{1, 1, 0, 1, 1, 1, 1};
      int exp_c  [7] = '{0, 0, 0, 1, 1, 1, 2};
      for (int k = 0; k < 7; k++) begin
        bus.i_en = en_pat[k];
        cyc();
        chk("presc_cnt", 32'(bus.o_cnt), 32'(exp_c[k]));
      end
    end

    // priority
    bus.i_presc = '0; bus.i_en = 1;
    bus.i_clr = 1; bus.i_load = 1; bus.i_load_val = 8'd9; cyc();
    chk("prio_clr", 32'(bus.o_cnt), 0);
    bus.i_clr = 0; cyc();
    chk("prio_load", 32'(bus.o_cnt), 9);
    i_rst_n = 0; cyc();
    chk("prio_rst", 32'(bus.o_cnt), 0);
    i_rst_n = 1; idle();

    // out-of-range load
    bus.i_max = 8'd10; bus.i_load = 1; bus.i_load_val = 8'd200; cyc();
    bus.i_load = 0; bus.i_en = 1; cyc();
    chk("oor_wrap_cnt", 32'(bus.o_cnt), 0);
    chk("oor_wrap_pls", 32'(bus.o_wrap), 1);
    idle(); bus.i_sat = 1; bus.i_load = 1; cyc();
    bus.i_load = 0; bus.i_en = 1; cyc();
    chk("oor_sat_cnt", 32'(bus.o_cnt), 10);
    idle(); bus.i_sat = 0; bus.i_max = 8'd255; bus.i_load = 1; bus.i_load_val = 8'd255; cyc();
    bus.i_load = 0; bus.i_en = 1; #1;
    chk("full_tc", 32'(bus.o_tc), 1);
    cyc();
    chk("full_wrap_cnt", 32'(bus.o_cnt), 0);

    // direction switch
    idle(); bus.i_max = 8'd7; bus.i_clr = 1; cyc();
    bus.i_clr = 0; bus.i_en = 1;
    repeat (5) cyc();
    chk("dir_up5", 32'(bus.o_cnt), 5);
    bus.i_up = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("dir_cnt", 32'(bus.o_cnt), 32'((k < 5) ? 4 - k : 7));
      chk("dir_wrap", 32'(bus.o_wrap), 32'(k == 5));
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_rst_n       = ($urandom_range(0, 127) != 0);
      bus.i_en      = ($urandom_range(0, 3) != 0);
      bus.i_clr     = ($urandom_range(0, 31) == 0);
      bus.i_load    = ($urandom_range(0, 31) == 0);
      bus.i_ovf_clr = ($urandom_range(0, 7) == 0);
      bus.i_load_val = W'($urandom);
      if ($urandom_range(0, 15) == 0) bus.i_up  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) bus.i_sat = 1'($urandom);
      if ($urandom_range(0, 63) == 0) bus.i_presc = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.i_max = '0;
          1: bus.i_max = 8'd1;
          2: bus.i_max = 8'd17;
          3: bus.i_max = 8'd255;
          default: bus.i_max = W'($urandom);
        endcase
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end
endmodule
